// File: rtl/det_engine_param.sv
// Exact NxN signed integer determinant by fraction-free (Bareiss) elimination.
// The matrix is streamed in row-major order; row swaps go through a permutation table.
module det_engine_param #(
  parameter int N     = 8,
  parameter int DW    = 8,
  parameter int ACC_W = 64
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic                    Ack,
  input  logic                    In_valid,
  input  logic signed [DW-1:0]    In_data,
  output logic                    In_ready,
  output logic signed [ACC_W-1:0] det,
  output logic                    Singular,
  output logic                    Overflow,
  output logic                    q_I,
  output logic                    q_Load,
  output logic                    q_Pivot,
  output logic                    q_Elim,
  output logic                    q_Done
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = (N > 1) ? $clog2(N * N) : 1;
  localparam int PW = 2 * ACC_W;
  localparam logic [IW-1:0] LAST     = IW'(N - 1);
  localparam logic [AW-1:0] CNT_LAST = AW'(N * N - 1);

  localparam logic [2:0] ST_I     = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_PIVOT = 3'd2;
  localparam logic [2:0] ST_ELIM  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]               state;
  logic [AW-1:0]            cnt;
  logic [IW-1:0]            k, r, i, j, kp1;
  logic                     sign_neg;
  logic signed [ACC_W-1:0]  prev;
  logic [IW-1:0]            perm [N];
  logic signed [ACC_W-1:0]  m [N*N];

  logic signed [ACC_W-1:0]  in_ext, m_kk, m_ij, m_ik, m_kj, m_rk, q_lo;
  logic signed [PW-1:0]     w_kk, w_ij, w_ik, w_kj, w_prev, num, quo, q_ext;
  logic                     q_fits;

  // Physical storage index of logical element (row, col) given the physical row.
  function automatic logic [AW-1:0] addr(input logic [IW-1:0] prow, input logic [IW-1:0] col);
    return AW'(int'(prow) * N + int'(col));
  endfunction

  always_comb begin
    in_ext = In_data;
    kp1    = k + IW'(1);
    m_kk   = m[addr(perm[k], k)];
    m_ij   = m[addr(perm[i], j)];
    m_ik   = m[addr(perm[i], k)];
    m_kj   = m[addr(perm[k], j)];
    m_rk   = m[addr(perm[r], k)];
    w_kk   = m_kk;
    w_ij   = m_ij;
    w_ik   = m_ik;
    w_kj   = m_kj;
    w_prev = prev;
    num    = w_ij * w_kk - w_ik * w_kj;
    quo    = num / w_prev;
    q_lo   = quo[ACC_W-1:0];
    q_ext  = q_lo;
    q_fits = (q_ext == quo);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      if (state == ST_LOAD && In_valid)
        m[cnt] <= in_ext;
      else if (state == ST_ELIM)
        m[addr(perm[i], j)] <= q_lo;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= ST_I;
      det      <= '0;
      Singular <= 1'b0;
      Overflow <= 1'b0;
      cnt      <= '0;
      k        <= '0;
      r        <= '0;
      i        <= '0;
      j        <= '0;
      sign_neg <= 1'b0;
      prev     <= ACC_W'(1);
      for (int unsigned p = 0; p < N; p++) perm[p] <= IW'(p);
    end else begin
      case (state)
        ST_I: if (Start) begin
          state    <= ST_LOAD;
          det      <= '0;
          Singular <= 1'b0;
          Overflow <= 1'b0;
          cnt      <= '0;
          for (int unsigned p = 0; p < N; p++) perm[p] <= IW'(p);
        end
        ST_LOAD: if (In_valid) begin
          cnt <= cnt + AW'(1);
          if (cnt == CNT_LAST) begin
            if (N == 1) begin
              state    <= ST_DONE;
              det      <= in_ext;
              Singular <= (in_ext == '0);
            end else begin
              state    <= ST_PIVOT;
              k        <= '0;
              r        <= '0;
              sign_neg <= 1'b0;
              prev     <= ACC_W'(1);
            end
          end
        end
        ST_PIVOT: begin
          if (m_rk != '0) begin
            if (r != k) begin
              perm[k]  <= perm[r];
              perm[r]  <= perm[k];
              sign_neg <= ~sign_neg;
            end
            state <= ST_ELIM;
            i     <= kp1;
            j     <= kp1;
          end else if (r != LAST) begin
            r <= r + IW'(1);
          end else begin
            det      <= '0;
            Singular <= 1'b1;
            state    <= ST_DONE;
          end
        end
        ST_ELIM: begin
          if (!q_fits) Overflow <= 1'b1;
          if (j != LAST) begin
            j <= j + IW'(1);
          end else if (i != LAST) begin
            i <= i + IW'(1);
            j <= kp1;
          end else begin
            // The final element written this edge is M[N-1][N-1] itself, so det comes from q_lo.
            prev <= m_kk;
            k    <= kp1;
            r    <= kp1;
            if (kp1 != LAST) begin
              state <= ST_PIVOT;
            end else begin
              state    <= ST_DONE;
              det      <= sign_neg ? -q_lo : q_lo;
              Singular <= (q_lo == '0);
            end
          end
        end
        ST_DONE: if (Ack) state <= ST_I;
        default: state <= ST_I;
      endcase
    end
  end

  always_comb begin
    q_I      = (state == ST_I);
    q_Load   = (state == ST_LOAD);
    q_Pivot  = (state == ST_PIVOT);
    q_Elim   = (state == ST_ELIM);
    q_Done   = (state == ST_DONE);
    In_ready = q_Load;
  end

endmodule

// File: tb/tb_det_engine_param.sv
// Directed bench for det_engine_param: three instances (N=8, N=3, N=2 with ACC_W=12).
module tb_det_engine_param;

  logic        Clk = 1'b0;
  logic        Reset, Ack, In_valid;
  logic [2:0]  start;
  logic signed [7:0] In_data;

  logic [2:0]  rdy, sing, ovf;
  logic [4:0]  st8, st3, st2;
  logic signed [63:0] det8, det3;
  logic signed [11:0] det2;

  int n_vec = 0;
  int n_err = 0;
  int mat [64];

  always #5 Clk = ~Clk;

  det_engine_param #(.N(8), .DW(8), .ACC_W(64)) u8 (
    .Clk(Clk), .Reset(Reset), .Start(start[0]), .Ack(Ack), .In_valid(In_valid),
    .In_data(In_data), .In_ready(rdy[0]), .det(det8), .Singular(sing[0]), .Overflow(ovf[0]),
    .q_I(st8[0]), .q_Load(st8[1]), .q_Pivot(st8[2]), .q_Elim(st8[3]), .q_Done(st8[4]));

  det_engine_param #(.N(3), .DW(8), .ACC_W(64)) u3 (
    .Clk(Clk), .Reset(Reset), .Start(start[1]), .Ack(Ack), .In_valid(In_valid),
    .In_data(In_data), .In_ready(rdy[1]), .det(det3), .Singular(sing[1]), .Overflow(ovf[1]),
    .q_I(st3[0]), .q_Load(st3[1]), .q_Pivot(st3[2]), .q_Elim(st3[3]), .q_Done(st3[4]));

  det_engine_param #(.N(2), .DW(8), .ACC_W(12)) u2 (
    .Clk(Clk), .Reset(Reset), .Start(start[2]), .Ack(Ack), .In_valid(In_valid),
    .In_data(In_data), .In_ready(rdy[2]), .det(det2), .Singular(sing[2]), .Overflow(ovf[2]),
    .q_I(st2[0]), .q_Load(st2[1]), .q_Pivot(st2[2]), .q_Elim(st2[3]), .q_Done(st2[4]));

  task automatic check_val(input string tag, input logic signed [63:0] got,
                           input logic signed [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] st_of(input int sel);
    case (sel)
      0:       return st8;
      1:       return st3;
      default: return st2;
    endcase
  endfunction

  function automatic logic signed [63:0] det_of(input int sel);
    logic signed [63:0] t;
    case (sel)
      0:       t = det8;
      1:       t = det3;
      default: t = det2;
    endcase
    return t;
  endfunction

  task automatic set_ident(input int n);
    for (int e = 0; e < 64; e++) mat[e] = 0;
    for (int d = 0; d < n; d++) mat[d * n + d] = 1;
  endtask

  task automatic set_base8();
    set_ident(8);
    mat[0]  = 6; mat[1]  = 1;  mat[2]  = 1;
    mat[8]  = 4; mat[9]  = -2; mat[10] = 5;
    mat[16] = 2; mat[17] = 8;  mat[18] = 7;
  endtask

  task automatic set9(input int a [9]);
    for (int e = 0; e < 9; e++) mat[e] = a[e];
  endtask

  // Starts a job on instance sel and streams n*n elements; returns at the negedge after the last load edge.
  task automatic load_job(input int sel, input int n, input bit gaps);
    @(negedge Clk); start[sel] = 1'b1;
    @(negedge Clk); start = '0;
    for (int e = 0; e < n * n; e++) begin
      if (gaps) begin In_valid = 1'b0; In_data = 8'sd0; @(negedge Clk); end
      In_valid = 1'b1;
      In_data  = 8'(mat[e]);
      @(negedge Clk);
    end
    In_valid = 1'b0;
  endtask

  task automatic wait_done(input int sel, output int cyc, output int piv0, output bit from_pivot);
    bit seen_elim = 1'b0;
    cyc = 0; piv0 = 0; from_pivot = 1'b0;
    while (!st_of(sel)[4] && cyc < 3000) begin
      if (st_of(sel)[3]) seen_elim = 1'b1;
      if (st_of(sel)[2] && !seen_elim) piv0++;
      from_pivot = st_of(sel)[2];
      @(negedge Clk);
      cyc++;
    end
    if (!st_of(sel)[4]) check_val("done_timeout", 0, 1);
  endtask

  task automatic wait_elim(input int sel);
    int c = 0;
    while (!st_of(sel)[3] && c < 500) begin @(negedge Clk); c++; end
    if (!st_of(sel)[3]) check_val("elim_timeout", 0, 1);
  endtask

  task automatic ack_job();
    @(negedge Clk); Ack = 1'b1;
    @(negedge Clk); Ack = 1'b0;
  endtask

  initial begin
    int cyc, piv0;
    bit fp;
    Reset = 1'b1; Ack = 1'b0; In_valid = 1'b0; In_data = 8'sd0; start = '0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;

    check_val("rst_qI",   st8[0], 1);
    check_val("rst_det",  det8, 0);
    check_val("rst_sing", sing[0], 0);
    check_val("rst_ovf",  ovf[0], 0);
    check_val("rst_rdy",  rdy[0], 0);
    check_val("rst_qI_3", st3[0], 1);
    check_val("rst_qI_2", st2[0], 1);

    // 8x8 with 3x3 block in the corner, no swaps
    set_base8();
    load_job(0, 8, 1'b0);
    wait_done(0, cyc, piv0, fp);
    check_val("t1_cycles", cyc, 147);
    check_val("t1_det",  det8, -306);
    check_val("t1_sing", sing[0], 0);
    check_val("t1_ovf",  ovf[0], 0);
    ack_job();
    check_val("t1_ack_qI", st8[0], 1);
    check_val("t1_held",  det8, -306);

    // permutation matrix: one swap at k=0
    set9('{0, 1, 0, 1, 0, 0, 0, 0, 1});
    load_job(1, 3, 1'b0);
    wait_done(1, cyc, piv0, fp);
    check_val("t2_piv0",   piv0, 2);
    check_val("t2_cycles", cyc, 8);
    check_val("t2_det",    det3, -1);
    check_val("t2_sing",   sing[1], 0);
    ack_job();

    // rank 2: ends through elimination with a zero corner
    set9('{1, 2, 3, 2, 4, 6, 1, 1, 1});
    load_job(1, 3, 1'b0);
    wait_done(1, cyc, piv0, fp);
    check_val("t3_sing", sing[1], 1);
    check_val("t3_det",  det3, 0);
    ack_job();

    // rank 1: no pivot found at k=1
    set9('{1, 2, 3, 2, 4, 6, 3, 6, 9});
    load_job(1, 3, 1'b0);
    wait_done(1, cyc, piv0, fp);
    check_val("t3b_sing",   sing[1], 1);
    check_val("t3b_det",    det3, 0);
    check_val("t3b_frompv", fp, 1);
    ack_job();

    // 12-bit accumulator overflow
    mat[0] = 100; mat[1] = 0; mat[2] = 0; mat[3] = 100;
    load_job(2, 2, 1'b0);
    wait_done(2, cyc, piv0, fp);
    check_val("t4_ovf", ovf[2], 1);
    ack_job();

    // reset mid-elimination, then identity
    set_base8();
    load_job(0, 8, 1'b0);
    wait_elim(0);
    @(negedge Clk); Reset = 1'b1;
    @(negedge Clk); Reset = 1'b0;
    check_val("t5_qI",   st8[0], 1);
    check_val("t5_det",  det8, 0);
    check_val("t5_sing", sing[0], 0);
    check_val("t5_ovf",  ovf[0], 0);
    set_ident(8);
    load_job(0, 8, 1'b0);
    wait_done(0, cyc, piv0, fp);
    check_val("t5_id_det",  det8, 1);
    check_val("t5_id_sing", sing[0], 0);
    ack_job();

    // gapped load and a stray Start during elimination
    set_base8();
    load_job(0, 8, 1'b1);
    wait_elim(0);
    @(negedge Clk); start[0] = 1'b1;
    @(negedge Clk); start[0] = 1'b0;
    check_val("t6_noload", st8[1], 0);
    wait_done(0, cyc, piv0, fp);
    check_val("t6_det",  det8, -306);
    check_val("t6_ovf",  ovf[0], 0);
    Ack = 1'b1;
    @(negedge Clk); Ack = 1'b0;
    check_val("t6_ack_qI", st8[0], 1);
    check_val("t6_held",   det_of(0), -306);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
